// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared FSM states, size codes and load lane extraction for mem_lsu
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    return sz == SZ_HALF ? off[0] : sz == SZ_WORD ? |off : sz != SZ_BYTE;
  endfunction
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic uns);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    return sz == SZ_BYTE ? {{24{b[7] & ~uns}}, b} : sz == SZ_HALF ? {{16{h[15] & ~uns}}, h} : w;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte/half merge into an old word and load lane extract/extend
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged,
  output logic [31:0] load_data
);
  always_comb begin
    merged = old_word;
    if (size == SZ_BYTE) merged[{off, 3'b000} +: 8] = wdata[7:0];
    else if (size == SZ_HALF) merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
  end
  assign load_data = lane_extract(old_word, size, off, uns);
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit for a word-wide byte-addressed RAM
module mem_lsu
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  lsu_state_t state, state_n;
  logic we_r, uns_r, err_r, accept;
  logic [1:0] size_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r, rdata_r, merged, load_data;
  lsu_lane_align u_align (
    .size(size_r), .uns(uns_r), .off(addr_r[1:0]), .wdata(data_r),
    .old_word(mem_rdata), .merged(merged), .load_data(load_data)
  );
  assign req_ready  = reset_n && state == IDLE;
  assign accept     = req_valid && req_ready;
  assign resp_valid = state == RESP;
  assign resp_err   = resp_valid && err_r;
  assign resp_rdata = resp_valid ? rdata_r : '0;
  assign mem_we     = state == WRITE;
  assign mem_addr   = {addr_r[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata  = mem_we ? data_r : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = misaligned(req_size, req_addr[1:0]) ? RESP :
                                     (req_we && req_size == SZ_WORD) ? WRITE : READ;
      READ:    state_n = we_r ? WRITE : RESP;
      WRITE:   state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // data_r holds the store word; sub-word stores overwrite it with the merge in READ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      err_r   <= 1'b0;
      size_r  <= SZ_BYTE;
      addr_r  <= '0;
      data_r  <= '0;
      rdata_r <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_r    <= req_we;
        uns_r   <= req_unsigned;
        size_r  <= req_size;
        addr_r  <= req_addr;
        data_r  <= req_wdata;
        rdata_r <= '0;
        err_r   <= misaligned(req_size, req_addr[1:0]);
      end else if (state == READ) begin
        if (we_r) data_r <= merged;
        else rdata_r <= load_data;
      end
    end
  end
endmodule
